// File: rtl/gerador_melodia.sv
// Note-sequence transmitter for the ok/tom/nota interface; plays one word-type melody per request.
// Optional completed-sequence counter port "contagem" is built when CONTAGEM_EN is defined.
module gerador_melodia #(
  parameter int GAP   = 1,
  parameter int GAP_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inicio,
  input  logic [1:0] tipo,
  input  logic       variante,
  output logic       ok,
  output logic       tom,
  output logic [2:0] nota,
  output logic       ocupado,
  output logic       pronto
`ifdef CONTAGEM_EN
  ,
  output logic [7:0] contagem
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } estado_t;

  localparam logic [GAP_W-1:0] GAP_V = GAP_W'(GAP);
  localparam logic [GAP_W-1:0] UM_V  = {{(GAP_W-1){1'b0}}, 1'b1};

  // {tom, nota} of symbol i for word type t and variant v
  function automatic logic [3:0] simbolo(input logic [1:0] t, input logic v, input logic [2:0] i);
    logic [3:0] s;
    s = 4'b0000;
    case (t)
      2'b01: begin
        case (i)
          3'd0:    s = 4'b0001;
          3'd1:    s = 4'b0010;
          3'd2:    s = 4'b0011;
          3'd3:    s = 4'b0100;
          3'd4:    s = v ? 4'b0111 : 4'b0110;
          default: s = 4'b0000;
        endcase
      end
      2'b10: begin
        case (i)
          3'd0:    s = 4'b0001;
          3'd1:    s = 4'b0011;
          3'd2:    s = 4'b0101;
          3'd3:    s = v ? 4'b0111 : 4'b0110;
          3'd4:    s = v ? 4'b1010 : 4'b1001;
          default: s = 4'b0000;
        endcase
      end
      2'b11: begin
        case (i)
          3'd0:    s = 4'b0010;
          3'd1:    s = 4'b0100;
          3'd2:    s = 4'b0101;
          3'd3:    s = 4'b0110;
          3'd4:    s = 4'b0111;
          default: s = 4'b0000;
        endcase
      end
      default: begin
        case (i)
          3'd0:    s = 4'b0001;
          default: s = 4'b0000;
        endcase
      end
    endcase
    return s;
  endfunction

  estado_t          estado_r, estado_s;
  logic [2:0]       indice_r, indice_s;
  logic [GAP_W-1:0] espera_r, espera_s;
  logic [1:0]       tipo_r, tipo_s;
  logic             var_r, var_s;
  logic [2:0]       ultimo_s;
  logic [3:0]       simbolo_s;
  logic             ok_r, tom_r, ocupado_r, pronto_r;
  logic [2:0]       nota_r;

  assign ultimo_s  = (tipo_r == 2'b00) ? 3'd1 : 3'd5;
  assign simbolo_s = simbolo(tipo_s, var_s, indice_s);

  // Next-state, symbol index, gap countdown and start-time latches
  always_comb begin
    estado_s = estado_r;
    indice_s = indice_r;
    espera_s = espera_r;
    tipo_s   = tipo_r;
    var_s    = var_r;
    case (estado_r)
      IDLE: begin
        if (inicio) begin
          estado_s = EMIT;
          indice_s = 3'd0;
          tipo_s   = tipo;
          var_s    = variante;
        end else begin
          estado_s = IDLE;
        end
      end
      EMIT: begin
        if (indice_r == ultimo_s) begin
          estado_s = DONE;
        end else begin
          indice_s = indice_r + 3'd1;
          if (GAP == 0) begin
            estado_s = EMIT;
          end else begin
            estado_s = WAIT;
            espera_s = GAP_V;
          end
        end
      end
      WAIT: begin
        if (espera_r <= UM_V) begin
          estado_s = EMIT;
        end else begin
          espera_s = espera_r - UM_V;
        end
      end
      DONE:    estado_s = IDLE;
      default: estado_s = IDLE;
    endcase
  end

  // State registers; outputs are registered from the next state so they line up with it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_r  <= IDLE;
      indice_r  <= 3'd0;
      espera_r  <= {GAP_W{1'b0}};
      tipo_r    <= 2'b00;
      var_r     <= 1'b0;
      ok_r      <= 1'b0;
      tom_r     <= 1'b0;
      nota_r    <= 3'b000;
      ocupado_r <= 1'b0;
      pronto_r  <= 1'b0;
    end else begin
      estado_r  <= estado_s;
      indice_r  <= indice_s;
      espera_r  <= espera_s;
      tipo_r    <= tipo_s;
      var_r     <= var_s;
      ok_r      <= (estado_s == EMIT);
      tom_r     <= (estado_s == EMIT) ? simbolo_s[3] : 1'b0;
      nota_r    <= (estado_s == EMIT) ? simbolo_s[2:0] : 3'b000;
      ocupado_r <= (estado_s == EMIT) || (estado_s == WAIT);
      pronto_r  <= (estado_s == DONE);
    end
  end

  assign ok      = ok_r;
  assign tom     = tom_r;
  assign nota    = nota_r;
  assign ocupado = ocupado_r;
  assign pronto  = pronto_r;

`ifdef CONTAGEM_EN
  logic [7:0] contagem_r;

  // Completed-sequence counter, visible together with the pronto pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      contagem_r <= 8'd0;
    end else if (estado_s == DONE) begin
      contagem_r <= contagem_r + 8'd1;
    end else begin
      contagem_r <= contagem_r;
    end
  end

  assign contagem = contagem_r;
`endif

endmodule
